// File: rtl/udp_tx_pkg.sv
// Shared types and protocol constants for the UDP transmit framer.
package udp_tx_pkg;

    typedef enum logic [2:0] {IDLE, CSUM, HDR, SPLICE, PAYLOAD, TAIL, PAD} state_e;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] IP_VER_IHL     = 16'h4500;
    localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
    localparam logic [7:0]  PROTO_UDP      = 8'h11;

    localparam int          HDR_WORDS      = 10;
    localparam logic [15:0] IP_OVERHEAD    = 16'd28;
    localparam logic [15:0] UDP_OVERHEAD   = 16'd8;

    // Byte length of a header plus a payload given in 32-bit words.
    function automatic logic [15:0] len_bytes(input logic [15:0] words, input logic [15:0] overhead);
        return overhead + {words[13:0], 2'b00};
    endfunction

endpackage

// File: rtl/udp_tx_framer_if.sv
// Config, payload and MAC-transmit signals of the framer; master is the framer side.
interface udp_tx_framer_if #(parameter int LEN_W = 11);
    logic [47:0]      src_mac;
    logic [47:0]      dst_mac;
    logic [31:0]      src_ip;
    logic [31:0]      dst_ip;
    logic [15:0]      src_port;
    logic [15:0]      dst_port;
    logic             start;
    logic [LEN_W-1:0] length;
    logic             busy;
    logic [31:0]      pl_data;
    logic             pl_valid;
    logic             pl_ready;
    logic [31:0]      tx_data;
    logic             tx_sof;
    logic             tx_we;
    logic             tx_stop;
    logic [31:0]      frame_count;

    modport master (
        input  src_mac, dst_mac, src_ip, dst_ip, src_port, dst_port, start, length,
               pl_data, pl_valid, tx_stop,
        output busy, pl_ready, tx_data, tx_sof, tx_we, frame_count
    );

    modport slave (
        output src_mac, dst_mac, src_ip, dst_ip, src_port, dst_port, start, length,
               pl_data, pl_valid, tx_stop,
        input  busy, pl_ready, tx_data, tx_sof, tx_we, frame_count
    );
endinterface

// File: rtl/ip_csum_acc.sv
// 16-bit one's-complement accumulator; the end-around carry is folded on every add.
module ip_csum_acc (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        add_i,
    input  logic [15:0] data_i,
    output logic [15:0] sum_o
);
    logic [15:0] acc_q;
    logic [16:0] raw;

    assign raw   = {1'b0, acc_q} + {1'b0, data_i};
    assign sum_o = acc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      acc_q <= '0;
        else if (clr_i) acc_q <= '0;
        else if (add_i) acc_q <= raw[15:0] + {15'd0, raw[16]};
    end
endmodule

// File: rtl/udp_tx_framer.sv
// Ethernet/IPv4/UDP frame builder feeding the raw MAC transmit FIFO, payload realigned by 16 bits.
module udp_tx_framer
    import udp_tx_pkg::*;
#(
    parameter int         LEN_W     = 11,
    parameter int         MIN_WORDS = 16,
    parameter logic [7:0] TTL       = 8'h40
) (
    input logic             usr_clk,
    input logic             reset,
    udp_tx_framer_if.master bus
);
    localparam int WCNT_W = LEN_W + 1;

    state_e            state_q, state_d;
    logic [3:0]        step_q, step_d;
    logic [LEN_W-1:0]  n_q, rem_q, rem_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
    logic [15:0]       hold_q, hold_d, ident_q, ident_d;
    logic [31:0]       fcnt_q, fcnt_d;
    logic              busy_q, busy_d;
    logic [47:0]       src_mac_q, dst_mac_q;
    logic [31:0]       src_ip_q, dst_ip_q;
    logic [15:0]       src_port_q, dst_port_q;

    logic        accept, avail, we, sof, ready, last;
    logic [31:0] data, hdr_word;
    logic [15:0] field, csum_sum, tot_len, udp_len;

    assign tot_len = len_bytes(16'(n_q), IP_OVERHEAD);
    assign udp_len = len_bytes(16'(n_q), UDP_OVERHEAD);

    ip_csum_acc u_csum (
        .clk_i  (usr_clk),
        .rst_i  (reset),
        .clr_i  (accept),
        .add_i  (state_q == CSUM),
        .data_i (field),
        .sum_o  (csum_sum)
    );

    always_comb begin
        field    = '0;
        hdr_word = '0;
        unique case (step_q)
            4'd0: begin field = IP_VER_IHL;          hdr_word = dst_mac_q[47:16]; end
            4'd1: begin field = tot_len;             hdr_word = {dst_mac_q[15:0], src_mac_q[47:32]}; end
            4'd2: begin field = ident_q;             hdr_word = src_mac_q[31:0]; end
            4'd3: begin field = IP_FLAGS_DF;         hdr_word = {ETHERTYPE_IPV4, IP_VER_IHL}; end
            4'd4: begin field = {TTL, PROTO_UDP};    hdr_word = {tot_len, ident_q}; end
            4'd5: begin field = '0;                  hdr_word = {IP_FLAGS_DF, TTL, PROTO_UDP}; end
            4'd6: begin field = src_ip_q[31:16];     hdr_word = {~csum_sum, src_ip_q[31:16]}; end
            4'd7: begin field = src_ip_q[15:0];      hdr_word = {src_ip_q[15:0], dst_ip_q[31:16]}; end
            4'd8: begin field = dst_ip_q[31:16];     hdr_word = {dst_ip_q[15:0], src_port_q}; end
            default: begin field = dst_ip_q[15:0];   hdr_word = {dst_port_q, udp_len}; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        rem_d    = rem_q;
        wcnt_d   = wcnt_q;
        hold_d   = hold_q;
        busy_d   = busy_q;
        ident_d  = ident_q;
        fcnt_d   = fcnt_q;
        accept   = 1'b0;
        avail    = 1'b0;
        sof      = 1'b0;
        ready    = 1'b0;
        data     = '0;
        wcnt_inc = wcnt_q + WCNT_W'(1);
        last     = (wcnt_inc >= WCNT_W'(MIN_WORDS));

        unique case (state_q)
            IDLE: begin
                if (bus.start && (bus.length != '0)) begin
                    accept  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = CSUM;
                    step_d  = '0;
                    rem_d   = bus.length;
                    wcnt_d  = '0;
                end
            end
            CSUM: begin
                step_d = step_q + 4'd1;
                if (step_q == 4'(HDR_WORDS - 1)) begin
                    step_d  = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                avail = 1'b1;
                data  = hdr_word;
                sof   = (step_q == 4'd0);
            end
            SPLICE: begin
                ready = ~bus.tx_stop;
                avail = bus.pl_valid;
                data  = {16'h0000, bus.pl_data[31:16]};
            end
            PAYLOAD: begin
                ready = ~bus.tx_stop;
                avail = bus.pl_valid;
                data  = {hold_q, bus.pl_data[31:16]};
            end
            TAIL: begin
                avail = 1'b1;
                data  = {hold_q, 16'h0000};
            end
            PAD: avail = 1'b1;
            default: state_d = IDLE;
        endcase

        we = avail & ~bus.tx_stop;

        // Everything past CSUM advances only on an actual write into the FIFO.
        if (we) begin
            wcnt_d = wcnt_inc;
            unique case (state_q)
                HDR: begin
                    step_d = step_q + 4'd1;
                    if (step_q == 4'(HDR_WORDS - 1)) state_d = SPLICE;
                end
                SPLICE, PAYLOAD: begin
                    hold_d  = bus.pl_data[15:0];
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? TAIL : PAYLOAD;
                end
                TAIL, PAD: begin
                    if (last) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        ident_d = ident_q + 16'd1;
                        fcnt_d  = fcnt_q + 32'd1;
                    end else begin
                        state_d = PAD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge usr_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            rem_q   <= '0;
            wcnt_q  <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            ident_q <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            wcnt_q  <= wcnt_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            ident_q <= ident_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_ff @(posedge usr_clk or posedge reset) begin
        if (reset) begin
            n_q        <= '0;
            src_mac_q  <= '0;
            dst_mac_q  <= '0;
            src_ip_q   <= '0;
            dst_ip_q   <= '0;
            src_port_q <= '0;
            dst_port_q <= '0;
        end else if (accept) begin
            n_q        <= bus.length;
            src_mac_q  <= bus.src_mac;
            dst_mac_q  <= bus.dst_mac;
            src_ip_q   <= bus.src_ip;
            dst_ip_q   <= bus.dst_ip;
            src_port_q <= bus.src_port;
            dst_port_q <= bus.dst_port;
        end
    end

    assign bus.tx_we       = we;
    assign bus.tx_data     = data;
    assign bus.tx_sof      = sof;
    assign bus.pl_ready    = ready;
    assign bus.busy        = busy_q;
    assign bus.frame_count = fcnt_q;
endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed bench for udp_tx_framer: captured frames are compared with a reference model and a hand-computed table.
module tb_udp_tx_framer;
    localparam logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] DST_MAC  = 48'h02_00_00_00_00_02;
    localparam logic [31:0] SRC_IP   = 32'hC0A8_0001;
    localparam logic [31:0] DST_IP   = 32'hC0A8_0002;
    localparam logic [15:0] SRC_PORT = 16'h1234;
    localparam logic [15:0] DST_PORT = 16'h5678;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    udp_tx_framer_if #(.LEN_W(11)) bus ();

    udp_tx_framer #(.LEN_W(11), .MIN_WORDS(16), .TTL(8'h40)) dut (
        .usr_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] pay [16];
    logic [31:0] cap_data [$];
    logic        cap_sof  [$];

    typedef struct {
        int          frame;
        int          idx;
        logic [31:0] exp;
    } vec_t;
    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic int frame_words(input int n);
        return (11 + n < 16) ? 16 : 11 + n;
    endfunction

    function automatic logic [31:0] exp_word(input int i, input int n, input logic [15:0] id);
        logic [15:0] tl, ul, cs;
        logic [31:0] s;
        tl = 16'(28 + 4 * n);
        ul = 16'(8 + 4 * n);
        s  = 32'h4500 + {16'h0, tl} + {16'h0, id} + 32'h4000 + 32'h4011
           + {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
           + {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]};
        s  = (s & 32'hFFFF) + (s >> 16);
        s  = (s & 32'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        case (i)
            0: return DST_MAC[47:16];
            1: return {DST_MAC[15:0], SRC_MAC[47:32]};
            2: return SRC_MAC[31:0];
            3: return 32'h0800_4500;
            4: return {tl, id};
            5: return 32'h4000_4011;
            6: return {cs, SRC_IP[31:16]};
            7: return {SRC_IP[15:0], DST_IP[31:16]};
            8: return {DST_IP[15:0], SRC_PORT};
            9: return {DST_PORT, ul};
            default: ;
        endcase
        if (i == 10) return {16'h0000, pay[0][31:16]};
        if (i > 10 && i < 10 + n) return {pay[i-11][15:0], pay[i-10][31:16]};
        if (i == 10 + n) return {pay[n-1][15:0], 16'h0000};
        return 32'h0;
    endfunction

    // Drives one frame cycle by cycle; inputs change #1 after posedge, outputs sampled at negedge.
    task automatic run_frame(input int n, input bit stall, input bit busy_pulse, input int abort_at);
        int pk, cyc, stall_ctr, total;
        bit hs;
        cap_data.delete();
        cap_sof.delete();
        pk = 0;
        stall_ctr = 0;
        total = frame_words(n);
        bus.start  = 1'b1;
        bus.length = 11'(n);
        @(posedge clk); #1;
        bus.start  = 1'b0;
        for (cyc = 0; cyc < 400; cyc++) begin
            if (!bus.busy) break;
            if (abort_at != 0 && cap_data.size() == abort_at) break;
            bus.tx_stop = 1'b0;
            if (stall && cap_data.size() == 9 && stall_ctr < 3) begin
                bus.tx_stop = 1'b1;
                stall_ctr++;
            end else if (stall && cap_data.size() >= 10) begin
                bus.tx_stop = cyc[0];
            end
            bus.start    = busy_pulse && (cyc == 3 || cap_data.size() == total - 1);
            bus.length   = 11'd3;
            bus.pl_valid = 1'b1;
            bus.pl_data  = pay[pk];
            @(negedge clk);
            if (bus.tx_stop) begin
                check("we_during_stop", cap_data.size(), 32'(bus.tx_we), 32'd0);
                check("ready_during_stop", cap_data.size(), 32'(bus.pl_ready), 32'd0);
            end
            if (bus.tx_we) begin
                cap_data.push_back(bus.tx_data);
                cap_sof.push_back(bus.tx_sof);
            end
            hs = bus.pl_valid && bus.pl_ready;
            @(posedge clk); #1;
            if (hs) pk++;
        end
        check("frame_timeout", n, 32'(cyc < 400), 32'd1);
        bus.start    = 1'b0;
        bus.length   = '0;
        bus.tx_stop  = 1'b0;
        bus.pl_valid = 1'b0;
    endtask

    task automatic verify(input int tag, input int n, input logic [15:0] id);
        int total;
        total = frame_words(n);
        check("word_count", tag, cap_data.size(), total);
        for (int i = 0; i < cap_data.size() && i < total; i++) begin
            check("sof", i, 32'(cap_sof[i]), 32'(i == 0));
            check("word", i, cap_data[i], exp_word(i, n, id));
        end
        for (int v = 0; v < NV; v++) begin
            if (vecs[v].frame == tag && vecs[v].idx < cap_data.size())
                check("vec", v, cap_data[vecs[v].idx], vecs[v].exp);
        end
    endtask

    task automatic check_reset_state(input int tag);
        check("rst_busy", tag, 32'(bus.busy), 32'd0);
        check("rst_ready", tag, 32'(bus.pl_ready), 32'd0);
        check("rst_we", tag, 32'(bus.tx_we), 32'd0);
        check("rst_sof", tag, 32'(bus.tx_sof), 32'd0);
        check("rst_data", tag, bus.tx_data, 32'd0);
        check("rst_fcount", tag, bus.frame_count, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{0, 4,  32'h0030_0000};
        vecs[1]  = '{0, 6,  32'hB969_C0A8};
        vecs[2]  = '{0, 9,  32'h5678_001C};
        vecs[3]  = '{1, 10, 32'h0000_1122};
        vecs[4]  = '{1, 11, 32'h3344_5566};
        vecs[5]  = '{1, 16, 32'h0708_0000};
        vecs[6]  = '{2, 10, 32'h0000_AABB};
        vecs[7]  = '{2, 11, 32'hCCDD_0000};
        vecs[8]  = '{2, 15, 32'h0000_0000};
        vecs[9]  = '{4, 4,  32'h0024_0000};
        vecs[10] = '{5, 4,  32'h0028_0001};
        vecs[11] = '{6, 4,  32'h0030_0000};
        vecs[12] = '{6, 6,  32'hB969_C0A8};

        bus.src_mac  = SRC_MAC;
        bus.dst_mac  = DST_MAC;
        bus.src_ip   = SRC_IP;
        bus.dst_ip   = DST_IP;
        bus.src_port = SRC_PORT;
        bus.dst_port = DST_PORT;
        bus.start    = 1'b0;
        bus.length   = '0;
        bus.pl_data  = '0;
        bus.pl_valid = 1'b0;
        bus.tx_stop  = 1'b0;

        #2;
        check_reset_state(0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // length == 0 is ignored
        bus.start  = 1'b1;
        bus.length = '0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("len0_busy", 0, 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        check("len0_busy_late", 0, 32'(bus.busy), 32'd0);

        for (int k = 0; k < 16; k++) pay[k] = 32'hA000_0000 + 32'(k * 32'h0101_0101);
        run_frame(5, 0, 0, 0);
        verify(0, 5, 16'd0);

        pay[0] = 32'h1122_3344; pay[1] = 32'h5566_7788; pay[2] = 32'h99AA_BBCC;
        pay[3] = 32'hDDEE_FF00; pay[4] = 32'h0102_0304; pay[5] = 32'h0506_0708;
        run_frame(6, 0, 0, 0);
        verify(1, 6, 16'd1);

        pay[0] = 32'hAABB_CCDD;
        run_frame(1, 0, 0, 0);
        verify(2, 1, 16'd2);

        pay[0] = 32'h1122_3344;
        run_frame(6, 1, 0, 0);
        verify(3, 6, 16'd3);
        check("fcount_4", 0, bus.frame_count, 32'd4);

        rst = 1'b1;
        #1;
        check_reset_state(1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back frames with stray start pulses while busy
        run_frame(2, 0, 1, 0);
        verify(4, 2, 16'd0);
        run_frame(3, 0, 1, 0);
        verify(5, 3, 16'd1);
        @(posedge clk); #1;
        check("seq_idle_busy", 0, 32'(bus.busy), 32'd0);
        check("seq_fcount", 0, bus.frame_count, 32'd2);

        // Reset in the middle of the payload
        run_frame(8, 0, 0, 12);
        bus.pl_valid = 1'b1;
        bus.tx_stop  = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_we", 0, 32'(bus.tx_we), 32'd0);
        check("midrst_busy", 0, 32'(bus.busy), 32'd0);
        check("midrst_fcount", 0, bus.frame_count, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("midrst_no_write", c, 32'(bus.tx_we), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.pl_valid = 1'b0;
        @(negedge clk);
        check("postrst_no_write", 0, 32'(bus.tx_we), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) pay[k] = 32'hA000_0000 + 32'(k * 32'h0101_0101);
        run_frame(5, 0, 0, 0);
        verify(6, 5, 16'd0);
        check("final_fcount", 0, bus.frame_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
